// File: rtl/common_pkg.sv
// Project-wide constants shared by pipeline stages.
package common;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
endpackage

// File: rtl/pipes_pkg.sv
// Inter-stage record types and fetch-stage enums.
package pipes;
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_t;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Fetch PC register with next-PC mux: hold, +4 (wraps mod 2^64) or load target.
module pc_reg
    import pipes::*;
#(
    parameter logic [63:0] RESET_PC = common::RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  pc_sel_t     sel,
    input  logic [63:0] target,
    output logic [63:0] pc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else begin
            case (sel)
                PC_INC:  pc <= pc + 64'd4;
                PC_LOAD: pc <= target;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the ibus request/response handshake,
// and produces a registered F/D record; one cycle from accepted response to f_*.
module fetch_stage
    import pipes::*;
#(
    parameter logic [63:0] RESET_PC = common::RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stallF,
    input  logic        flushF,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_instr
);

    fetch_state_t state, state_nxt;
    fetch_data_t  fd;
    logic [63:0]  pc;
    logic [63:0]  pend_pc, pend_pc_nxt;
    logic         pend, pend_nxt;
    logic [31:0]  hold_instr;
    logic         hold_ld;
    logic         deliver;
    logic [31:0]  dlv_instr;
    pc_sel_t      pc_sel;
    logic [63:0]  pc_tgt;
    logic         kill;
    logic [63:0]  kill_pc;
    logic [63:0]  drain_pc;

    assign kill     = redirect_valid | flushF;
    assign kill_pc  = redirect_valid ? redirect_pc : pc;
    // A redirect arriving in the same cycle as the draining response still wins.
    assign drain_pc = redirect_valid ? redirect_pc : pend_pc;

    always_comb begin
        state_nxt   = state;
        pc_sel      = PC_HOLD;
        pc_tgt      = kill_pc;
        hold_ld     = 1'b0;
        pend_nxt    = pend;
        pend_pc_nxt = pend_pc;
        deliver     = 1'b0;
        dlv_instr   = iresp_data;
        case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                if (iresp_data_ok) begin
                    if (kill) begin
                        pc_sel = PC_LOAD;
                    end else if (stallF) begin
                        hold_ld   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        deliver = 1'b1;
                        pc_sel  = PC_INC;
                    end
                end else if (kill) begin
                    // The bus request cannot be withdrawn; wait for its response.
                    state_nxt   = DRAIN;
                    pend_nxt    = 1'b1;
                    pend_pc_nxt = kill_pc;
                end
            end
            HOLD: begin
                if (kill) begin
                    pc_sel    = PC_LOAD;
                    state_nxt = REQ;
                end else if (!stallF) begin
                    deliver   = 1'b1;
                    dlv_instr = hold_instr;
                    pc_sel    = PC_INC;
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pend_pc_nxt = redirect_pc;
                end
                if (iresp_data_ok) begin
                    pc_sel    = PC_LOAD;
                    pc_tgt    = pend ? drain_pc : pc;
                    pend_nxt  = 1'b0;
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .sel     (pc_sel),
        .target  (pc_tgt),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pend       <= 1'b0;
            pend_pc    <= 64'd0;
            hold_instr <= 32'd0;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            pend_pc <= pend_pc_nxt;
            if (hold_ld) begin
                hold_instr <= iresp_data;
            end
        end
    end

    // Flush beats stall; a stalled record is frozen, otherwise valid tracks delivery.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fd <= '0;
        end else if (flushF) begin
            fd.valid <= 1'b0;
        end else if (!stallF) begin
            fd.valid <= deliver;
            if (deliver) begin
                fd.pc    <= pc;
                fd.instr <= dlv_instr;
            end
        end
    end

    assign ireq_valid = (state == REQ) || (state == DRAIN);
    assign ireq_addr  = pc;
    assign f_valid    = fd.valid;
    assign f_pc       = fd.pc;
    assign f_instr    = fd.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: one vector per clock cycle.
module tb_fetch_stage;

    localparam logic [63:0] B    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] R1   = 64'h0000_0000_8000_1000;
    localparam logic [63:0] R2   = 64'h0000_0000_8000_2000;
    localparam logic [63:0] R3   = 64'h0000_0000_8000_3000;
    localparam logic [63:0] R4   = 64'h0000_0000_8000_4000;
    localparam logic [63:0] RW   = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NOP  = 32'hD503_201F;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
    localparam logic [31:0] I0   = 32'h1111_0000;
    localparam logic [31:0] I1   = 32'h1111_0001;
    localparam logic [31:0] I2   = 32'h1111_0002;
    localparam logic [31:0] I3   = 32'h1111_0003;
    localparam logic [31:0] I4   = 32'h1111_0004;
    localparam logic [31:0] I5   = 32'h1111_0005;
    localparam logic [31:0] I6   = 32'h1111_0006;
    localparam logic [31:0] I7   = 32'h1111_0007;
    localparam int NV = 27;

    typedef struct packed {
        logic        st;
        logic        fl;
        logic        rv;
        logic [63:0] rpc;
        logic        ok;
        logic [31:0] dat;
        logic        e_iv;
        logic [63:0] e_addr;
        logic        e_fv;
        logic [63:0] e_fpc;
        logic [31:0] e_fi;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stallF;
    logic        flushF;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        f_valid;
    logic [63:0] f_pc;
    logic [31:0] f_instr;

    int   n_vec;
    int   n_err;
    vec_t vt [NV];

    fetch_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stallF         (stallF),
        .flushF         (flushF),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .f_valid        (f_valid),
        .f_pc           (f_pc),
        .f_instr        (f_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic fl, input logic rv,
                                input logic [63:0] rpc, input logic ok, input logic [31:0] dat,
                                input logic e_iv, input logic [63:0] e_addr, input logic e_fv,
                                input logic [63:0] e_fpc, input logic [31:0] e_fi);
        vec_t v;
        v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc; v.ok = ok; v.dat = dat;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_fv = e_fv; v.e_fpc = e_fpc; v.e_fi = e_fi;
        return v;
    endfunction

    task automatic chk(input string name, input logic e_iv, input logic [63:0] e_addr,
                       input logic e_fv, input logic [63:0] e_fpc, input logic [31:0] e_fi);
        n_vec++;
        if (ireq_valid !== e_iv || ireq_addr !== e_addr || f_valid !== e_fv ||
            f_pc !== e_fpc || f_instr !== e_fi) begin
            n_err++;
            $display("FAIL %s: got iv=%0b addr=%h fv=%0b fpc=%h fi=%h, want iv=%0b addr=%h fv=%0b fpc=%h fi=%h",
                     name, ireq_valid, ireq_addr, f_valid, f_pc, f_instr,
                     e_iv, e_addr, e_fv, e_fpc, e_fi);
        end
    endtask

    task automatic drive(input vec_t v);
        stallF         = v.st;
        flushF         = v.fl;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        iresp_data_ok  = v.ok;
        iresp_data     = v.dat;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //             st fl rv rpc ok dat     iv addr      fv fpc     fi
        vt[0]  = mk(0, 0, 0, 0,  0, 0,     0, B,        0, 0,      0);
        vt[1]  = mk(0, 0, 0, 0,  1, I0,    1, B,        0, 0,      0);
        vt[2]  = mk(0, 0, 0, 0,  1, I1,    1, B + 4,    1, B,      I0);
        vt[3]  = mk(0, 0, 0, 0,  1, I2,    1, B + 8,    1, B + 4,  I1);
        vt[4]  = mk(0, 0, 0, 0,  0, 0,     1, B + 12,   1, B + 8,  I2);
        vt[5]  = mk(0, 0, 0, 0,  0, 0,     1, B + 12,   0, B + 8,  I2);
        vt[6]  = mk(0, 0, 0, 0,  1, I3,    1, B + 12,   0, B + 8,  I2);
        vt[7]  = mk(0, 0, 0, 0,  0, 0,     1, B + 16,   1, B + 12, I3);
        vt[8]  = mk(0, 0, 0, 0,  0, 0,     1, B + 16,   0, B + 12, I3);
        vt[9]  = mk(0, 0, 0, 0,  1, I4,    1, B + 16,   0, B + 12, I3);
        vt[10] = mk(1, 0, 0, 0,  1, NOP,   1, B + 20,   1, B + 16, I4);
        vt[11] = mk(1, 0, 0, 0,  0, 0,     0, B + 20,   1, B + 16, I4);
        vt[12] = mk(0, 0, 0, 0,  0, 0,     0, B + 20,   1, B + 16, I4);
        vt[13] = mk(0, 0, 0, 0,  0, 0,     1, B + 24,   1, B + 20, NOP);
        vt[14] = mk(0, 0, 1, R1, 0, 0,     1, B + 24,   0, B + 20, NOP);
        vt[15] = mk(0, 0, 0, 0,  0, 0,     1, B + 24,   0, B + 20, NOP);
        vt[16] = mk(0, 0, 0, 0,  1, JUNK,  1, B + 24,   0, B + 20, NOP);
        vt[17] = mk(0, 0, 0, 0,  1, I5,    1, R1,       0, B + 20, NOP);
        vt[18] = mk(0, 0, 1, R2, 1, JUNK,  1, R1 + 4,   1, R1,     I5);
        vt[19] = mk(0, 0, 0, 0,  1, I6,    1, R2,       0, R1,     I5);
        vt[20] = mk(1, 1, 0, 0,  0, 0,     1, R2 + 4,   1, R2,     I6);
        vt[21] = mk(0, 0, 1, R3, 0, 0,     1, R2 + 4,   0, R2,     I6);
        vt[22] = mk(0, 0, 0, 0,  1, JUNK,  1, R2 + 4,   0, R2,     I6);
        vt[23] = mk(0, 0, 1, RW, 1, JUNK,  1, R3,       0, R2,     I6);
        vt[24] = mk(0, 0, 0, 0,  1, I7,    1, RW,       0, R2,     I6);
        vt[25] = mk(0, 0, 1, R4, 0, 0,     1, 64'd0,    1, RW,     I7);
        vt[26] = mk(0, 0, 0, 0,  0, 0,     1, 64'd0,    0, RW,     I7);

        reset_n = 1'b0;
        drive(vt[0]);
        repeat (2) @(negedge clk);
        #1 chk("reset_state", 1'b0, B, 1'b0, 64'd0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            #1 chk($sformatf("vec%0d", i), vt[i].e_iv, vt[i].e_addr, vt[i].e_fv,
                   vt[i].e_fpc, vt[i].e_fi);
            @(negedge clk);
        end

        // Now in DRAIN (pending redirect to R4); reset mid-cycle must take effect at once.
        drive(vt[0]);
        #3 reset_n = 1'b0;
        #1 chk("async_reset_in_drain", 1'b0, B, 1'b0, 64'd0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("post_reset_idle", 1'b0, B, 1'b0, 64'd0, 32'd0);
        @(negedge clk);
        #1 chk("restart_from_reset_pc", 1'b1, B, 1'b0, 64'd0, 32'd0);
        iresp_data_ok = 1'b1;
        iresp_data    = I0;
        @(negedge clk);
        #1 chk("restart_first_delivery", 1'b1, B + 4, 1'b1, B, I0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
